trivium_decryptor: RTL and testbench

TRIVIUM_DECRYPTOR -- requirements
Module: trivium_decryptor

---
 rtl/trivium_decryptor_if.sv | 24 ++
 rtl/trivium_decryptor.sv | 130 +++++++++++++
 tb/tb_trivium_decryptor.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trivium_decryptor_if.sv
// Byte-stream and control bundle for the Trivium decryptor.
// The decryptor takes the slave modport. The driving side takes the master modport.
interface trivium_decryptor_if;
    logic        start;
    logic [79:0] key;
    logic [79:0] iv;
    logic        ready;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    modport slave (
        input  start, key, iv, in_valid, in_data, out_ready,
        output ready, in_ready, out_valid, out_data
    );

    modport master (
        output start, key, iv, in_valid, in_data, out_ready,
        input  ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/trivium_decryptor.sv
// Trivium stream decryptor: load key/IV, run WARMUP discarded updates, then XOR
// 8 keystream bits (z0 into the LSB) into each accepted ciphertext byte.
module trivium_decryptor #(
    parameter int WARMUP = 1152
) (
    input  logic                 clk,
    input  logic                 rst,
    trivium_decryptor_if.slave   bus
);
    localparam int CW = $clog2(WARMUP + 1);

    typedef enum logic [2:0] {IDLE, WARM, READY, SHIFT, OUT} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [287:0]   s_q, s_d;
    logic [7:0]     byte_q, byte_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           ready_q, ready_d;

    logic           t1, t2, t3, z;
    logic [287:0]   s_upd;
    logic [287:0]   s_load;
    logic [7:0]     byte_x;

    // Bit i-1 of s_q holds s_i.
    always_comb begin
        t1 = s_q[65]  ^ s_q[92];
        t2 = s_q[161] ^ s_q[176];
        t3 = s_q[242] ^ s_q[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s_q[90]  & s_q[91])  ^ s_q[170];
        t2 = t2 ^ (s_q[174] & s_q[175]) ^ s_q[263];
        t3 = t3 ^ (s_q[285] & s_q[286]) ^ s_q[68];
        s_upd  = {s_q[286:177], t2, s_q[175:93], t1, s_q[91:0], t3};
        s_load = {3'b111, 112'b0, bus.iv, 13'b0, bus.key};
        byte_x = byte_q;
        byte_x[bit_q] = byte_q[bit_q] ^ z;
    end

    // NOTE: every _d gets its hold value first so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        s_d         = s_q;
        byte_d      = byte_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ready_d     = ready_q;

        if (bus.start) begin
            // Restart wins over any handshake and discards an in-flight byte.
            state_d     = WARM;
            s_d         = s_load;
            cnt_d       = '0;
            bit_d       = '0;
            ready_d     = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                WARM: begin
                    if (cnt_q == CW'(WARMUP)) begin
                        state_d = READY;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        s_d   = s_upd;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (bus.in_valid) begin
                        byte_d  = bus.in_data;
                        bit_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    s_d    = s_upd;
                    byte_d = byte_x;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = byte_x;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_d     = READY;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            s_q         <= '0;
            byte_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            s_q         <= s_d;
            byte_q      <= byte_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.in_ready  = (state_q == READY) && !bus.start;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_trivium_decryptor.sv
// Directed bench for trivium_decryptor. A bit-serial reference model indexed
// s[1..288] supplies the expected keystream.
module tb_trivium_decryptor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trivium_decryptor_if bus();
    trivium_decryptor #(.WARMUP(1152)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [1:288] ms;

    localparam logic [79:0] K_RT = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] V_RT = 80'hFEDCBA98765432100F1E;
    localparam logic [79:0] K_RS = 80'h00000000000000000001;
    localparam logic [79:0] V_RS = 80'h80000000000000000002;

    task automatic model_load(input logic [79:0] k, input logic [79:0] v);
        ms = '0;
        for (int i = 1; i <= 80; i++) ms[i] = k[i-1];
        for (int j = 0; j < 80; j++) ms[94+j] = v[j];
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    endtask

    task automatic model_step(output logic zo);
        logic a, b, c;
        a = ms[66]  ^ ms[93];
        b = ms[162] ^ ms[177];
        c = ms[243] ^ ms[288];
        zo = a ^ b ^ c;
        a = a ^ (ms[91]  & ms[92])  ^ ms[171];
        b = b ^ (ms[175] & ms[176]) ^ ms[264];
        c = c ^ (ms[286] & ms[287]) ^ ms[69];
        ms = {c, ms[1:92], a, ms[94:176], b, ms[178:287]};
    endtask

    task automatic model_warm();
        logic zd;
        for (int i = 0; i < 1152; i++) model_step(zd);
    endtask

    task automatic model_byte(output logic [7:0] b);
        logic zb;
        for (int k = 0; k < 8; k++) begin
            model_step(zb);
            b[k] = zb;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [79:0] k, input logic [79:0] v);
        bus.key   = k;
        bus.iv    = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Edges from the start edge until ready is seen (bounded), plus in_ready activity.
    task automatic wait_ready(output int n, output logic ir_seen, output logic ov_seen);
        n = 0; ir_seen = 1'b0; ov_seen = 1'b0;
        while (!bus.ready && n < 1300) begin
            tick();
            n++;
            if (!bus.ready && bus.in_ready)  ir_seen = 1'b1;
            if (bus.out_valid)               ov_seen = 1'b1;
        end
    endtask

    // Offer one byte, return the first out_data seen and the edges it took.
    task automatic xfer(input logic [7:0] c, output logic [7:0] p, output int lat,
                        output logic busy_ir);
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        tick();
        bus.in_valid = 1'b0;
        lat = 0; busy_ir = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) busy_ir = 1'b1;
            tick();
            lat++;
        end
        p = bus.out_data;
    endtask

    task automatic test_reset();
        logic bad_idle;
        #1 rst = 1'b0;
        #1;
        total++; if (bus.ready !== 1'b0)     begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        total++; if (bus.in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        repeat (2) tick();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bad_idle = 1'b0;
        repeat (10) begin
            tick();
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.ready !== 1'b0) bad_idle = 1'b1;
        end
        bus.in_valid = 1'b0;
        total++; if (bad_idle !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=active exp=quiet"); end
    endtask

    task automatic test_warmup();
        int n; logic ir, ov;
        pulse_start(80'h0, 80'h0);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL warm_ready_early got=%b exp=0", bus.ready); end
        wait_ready(n, ir, ov);
        total++; if (n != 1153) begin bad++; $display("FAIL warm_latency got=%0d exp=1153", n); end
        total++; if (ir !== 1'b0) begin bad++; $display("FAIL warm_in_ready got=1 exp=0"); end
        model_load(80'h0, 80'h0);
        model_warm();
    endtask

    task automatic test_zero_stream();
        logic [7:0] p, e; int lat; logic busy;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL zs_in_ready byte=%0d got=%b exp=1", i, bus.in_ready); end
            model_byte(e);
            xfer(8'h00, p, lat, busy);
            total++; if (lat != 8) begin bad++; $display("FAIL zs_latency byte=%0d got=%0d exp=8", i, lat); end
            total++; if (p !== e)  begin bad++; $display("FAIL zs_data byte=%0d got=%h exp=%h", i, p, e); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL zs_busy_in_ready byte=%0d got=1 exp=0", i); end
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL zs_out_drop byte=%0d got=1 exp=0", i); end
        end
    endtask

    task automatic test_round_trip();
        int n, lat; logic ir, ov, busy; logic [7:0] ks, p;
        pulse_start(K_RT, V_RT);
        wait_ready(n, ir, ov);
        total++; if (n != 1153) begin bad++; $display("FAIL rt_warm_latency got=%0d exp=1153", n); end
        model_load(K_RT, V_RT);
        model_warm();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            model_byte(ks);
            xfer(8'(i) ^ ks, p, lat, busy);
            tick();
            total++; if (p !== 8'(i) || lat != 8) begin bad++; $display("FAIL rt_byte idx=%0d got=%h lat=%0d exp=%h lat=8", i, p, lat, 8'(i)); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e1, e2, p, p2; int lat; logic busy, held_bad;
        bus.out_ready = 1'b0;
        model_byte(e1);
        xfer(8'h3C, p, lat, busy);
        total++; if (lat != 8 || p !== (8'h3C ^ e1)) begin bad++; $display("FAIL bp_first got=%h lat=%0d exp=%h lat=8", p, lat, 8'h3C ^ e1); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        held_bad = 1'b0;
        repeat (20) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== p || bus.in_ready !== 1'b0) held_bad = 1'b1;
        end
        total++; if (held_bad !== 1'b0) begin bad++; $display("FAIL bp_hold got=changed exp=stable data=%h", p); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=ov%b ir%b exp=ov0 ir1", bus.out_valid, bus.in_ready); end
        model_byte(e2);
        xfer(8'h5A, p2, lat, busy);
        tick();
        total++; if (p2 !== (8'h5A ^ e2)) begin bad++; $display("FAIL bp_next got=%h exp=%h", p2, 8'h5A ^ e2); end
    endtask

    task automatic test_restart_in_shift();
        int n, lat; logic ir, ov, busy; logic [7:0] e, p;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        bus.in_valid = 1'b1;
        pulse_start(K_RS, V_RS);
        bus.in_valid = 1'b0;
        total++; if (bus.ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rs_drop got=rdy%b ov%b exp=rdy0 ov0", bus.ready, bus.out_valid); end
        wait_ready(n, ir, ov);
        total++; if (n != 1153) begin bad++; $display("FAIL rs_warm_latency got=%0d exp=1153", n); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rs_stale_out got=1 exp=0"); end
        model_load(K_RS, V_RS);
        model_warm();
        model_byte(e);
        xfer(8'h00, p, lat, busy);
        tick();
        total++; if (p !== e || lat != 8) begin bad++; $display("FAIL rs_byte0 got=%h lat=%0d exp=%h lat=8", p, lat, e); end
    endtask

    task automatic test_rst_in_warm();
        int n; logic ir, ov, quiet_bad;
        pulse_start(K_RT, V_RT);
        repeat (100) tick();
        rst = 1'b0;
        #1;
        total++; if (bus.ready !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            bad++; $display("FAIL rw_async got=rdy%b ir%b ov%b d%h exp=all0", bus.ready, bus.in_ready, bus.out_valid, bus.out_data);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        quiet_bad = 1'b0;
        repeat (1300) begin
            tick();
            if (bus.ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) quiet_bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        total++; if (quiet_bad !== 1'b0) begin bad++; $display("FAIL rw_idle got=active exp=quiet"); end
        pulse_start(K_RT, V_RT);
        wait_ready(n, ir, ov);
        total++; if (n != 1153) begin bad++; $display("FAIL rw_restart_latency got=%0d exp=1153", n); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key = '0;
        bus.iv = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_warmup();
        test_zero_stream();
        test_round_trip();
        test_backpressure();
        test_restart_in_shift();
        test_rst_in_warm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
